// File: rtl/fetch.sv
// fetch: instruction fetch front end.
// Walks sequential PCs from RESET_PC, keeps one instruction-memory request in
// flight, and hands PC/instr/excep/valid to decode through an output register
// backed by a one-entry skid buffer.
// Optional build macro FETCH_PERF_EN adds the perf_instr_count and
// perf_stall_cycles counters.

`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 31
`endif
`ifndef EX_WIDTH
`define EX_WIDTH 1
`endif
`ifndef EX_NONE
`define EX_NONE 2'd0
`endif
`ifndef EX_FETCH_FAULT
`define EX_FETCH_FAULT 2'd1
`endif
`ifndef EX_FETCH_MISALIGNED
`define EX_FETCH_MISALIGNED 2'd2
`endif

module fetch #(
    parameter logic [`ADDR_SIZE:0]  RESET_PC  = 32'h0000_0000,
    parameter logic [`INSTR_SIZE:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req_valid,
    output logic [`ADDR_SIZE:0]    imem_req_addr,
    input  logic                   imem_req_ready,
    input  logic                   imem_resp_valid,
    input  logic [`INSTR_SIZE:0]   imem_resp_data,
    input  logic                   imem_resp_err,
    output logic [`ADDR_SIZE:0]    PC_out,
    output logic [`INSTR_SIZE:0]   instr_out,
    output logic [`EX_WIDTH:0]     excep_out,
    output logic                   pipeline_out_valid,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [`ADDR_SIZE:0]    redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            perf_instr_count,
    output logic [31:0]            perf_stall_cycles
`endif
);

    localparam logic [`ADDR_SIZE:0] PC_STEP = 4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [`ADDR_SIZE:0]  r_pc;
    logic                 r_drop;

    logic                 r_out_valid;
    logic [`ADDR_SIZE:0]  r_out_pc;
    logic [`INSTR_SIZE:0] r_out_instr;
    logic [`EX_WIDTH:0]   r_out_excep;

    logic                 r_skid_full;
    logic [`ADDR_SIZE:0]  r_skid_pc;
    logic [`INSTR_SIZE:0] r_skid_instr;
    logic [`EX_WIDTH:0]   r_skid_excep;

    logic                 w_req_valid;
    logic                 w_req_fire;
    logic                 w_consume;
    logic                 w_out_free;
    logic                 w_new_entry;
    logic                 w_pc_adv;
    logic                 w_outstanding;
    logic [`ADDR_SIZE:0]  w_ent_pc;
    logic [`INSTR_SIZE:0] w_ent_instr;
    logic [`EX_WIDTH:0]   w_ent_excep;

    assign w_req_fire    = w_req_valid & imem_req_ready;
    assign w_consume     = r_out_valid & ~stall;
    assign w_out_free    = ~r_out_valid | w_consume;
    // A response is still owed after this cycle if one was pending and none arrived now.
    assign w_outstanding = (r_drop | (r_state == S_WAIT)) & ~imem_resp_valid;

    assign imem_req_valid     = w_req_valid;
    assign imem_req_addr      = r_pc;
    assign PC_out             = r_out_pc;
    assign instr_out          = r_out_instr;
    assign excep_out          = r_out_excep;
    assign pipeline_out_valid = r_out_valid;

    // Next-state, request issue and new output entry formation.
    always_comb begin
        w_state_next = r_state;
        w_req_valid  = 1'b0;
        w_new_entry  = 1'b0;
        w_pc_adv     = 1'b0;
        w_ent_pc     = r_pc;
        w_ent_instr  = NOP_INSTR;
        w_ent_excep  = `EX_NONE;
        case (r_state)
            S_REQ: begin
                // Hold off while a stale response is owed or the skid slot is taken.
                if (!r_skid_full && !r_drop) begin
                    if (r_pc[1:0] != 2'b00) begin
                        w_new_entry  = 1'b1;
                        w_ent_excep  = `EX_FETCH_MISALIGNED;
                        w_state_next = S_HALT;
                    end else begin
                        w_req_valid = reset;
                        if (reset && imem_req_ready) begin
                            w_state_next = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    w_new_entry = 1'b1;
                    w_ent_instr = imem_resp_data;
                    if (imem_resp_err) begin
                        w_ent_excep  = `EX_FETCH_FAULT;
                        w_state_next = S_HALT;
                    end else begin
                        w_pc_adv     = 1'b1;
                        w_state_next = S_REQ;
                    end
                end
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_REQ;
            end
        endcase
    end

    // State register; reset beats flush, flush restarts fetching.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_REQ;
        end else if (flush) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Fetch PC and the flag that swallows a response belonging to abandoned work.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc   <= RESET_PC;
            r_drop <= w_outstanding;
        end else if (flush) begin
            r_pc   <= redirect_pc;
            r_drop <= w_outstanding | w_req_fire;
        end else begin
            if (w_pc_adv) begin
                r_pc <= r_pc + PC_STEP;
            end
            if (r_drop && imem_resp_valid) begin
                r_drop <= 1'b0;
            end
        end
    end

    // Output register and skid buffer; output refills from skid first to keep PC order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_out_pc     <= '0;
            r_out_instr  <= '0;
            r_out_excep  <= `EX_NONE;
            r_skid_full  <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
            r_skid_excep <= `EX_NONE;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_skid_full <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_full) begin
                r_out_valid <= 1'b1;
                r_out_pc    <= r_skid_pc;
                r_out_instr <= r_skid_instr;
                r_out_excep <= r_skid_excep;
                r_skid_full <= 1'b0;
            end else if (w_new_entry) begin
                r_out_valid <= 1'b1;
                r_out_pc    <= w_ent_pc;
                r_out_instr <= w_ent_instr;
                r_out_excep <= w_ent_excep;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_new_entry) begin
            r_skid_full  <= 1'b1;
            r_skid_pc    <= w_ent_pc;
            r_skid_instr <= w_ent_instr;
            r_skid_excep <= w_ent_excep;
        end
    end

`ifdef FETCH_PERF_EN
    // Performance counters: clean instructions consumed, and cycles held by stall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_instr_count  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (w_consume && (r_out_excep == `EX_NONE)) begin
                perf_instr_count <= perf_instr_count + 32'd1;
            end
            if (stall && r_out_valid) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: scoreboard bench for the fetch stage. A memory model answers
// requests and queues the entry decode should see; a monitor pops and compares
// every consumed instruction; scenario tasks check stall, flush, exceptions and reset.

`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 31
`endif
`ifndef EX_WIDTH
`define EX_WIDTH 1
`endif
`ifndef EX_NONE
`define EX_NONE 2'd0
`endif
`ifndef EX_FETCH_FAULT
`define EX_FETCH_FAULT 2'd1
`endif
`ifndef EX_FETCH_MISALIGNED
`define EX_FETCH_MISALIGNED 2'd2
`endif

module tb_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  ex;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic [31:0] PC_out;
    logic [31:0] instr_out;
    logic [1:0]  excep_out;
    logic        pipeline_out_valid;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_instr_count;
    logic [31:0] perf_stall_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ent_t exp_q[$];
    int          mem_lat   = 1;
    int          drop_cnt  = 0;
    int          req_count = 0;
    logic [31:0] last_req_addr = 32'h0;
    bit          pend = 1'b0;
    logic [31:0] paddr = 32'h0;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;
    int          consumed = 0;
    logic [31:0] last_pc = 32'h0;
    logic [1:0]  last_ex = 2'd0;

    fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
        .PC_out(PC_out), .instr_out(instr_out), .excep_out(excep_out),
        .pipeline_out_valid(pipeline_out_valid),
        .stall(stall), .flush(flush), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
        , .perf_instr_count(perf_instr_count), .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory model: records accepted requests, answers after mem_lat cycles,
    // and queues the entry decode should receive unless a drop is expected.
    initial begin
        bit          fire;
        logic [31:0] fa;
        int          cnt;
        logic        e;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        imem_resp_err   = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clk);
            fire = imem_req_valid && imem_req_ready;
            fa   = imem_req_addr;
            if (fire) begin
                req_count++;
                last_req_addr = fa;
            end
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            imem_resp_err   = 1'b0;
            if (fire) begin
                pend  = 1'b1;
                paddr = fa;
                cnt   = mem_lat;
            end
            if (pend) begin
                if (cnt <= 1) begin
                    e = err_en && (paddr == err_addr);
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mdata(paddr);
                    imem_resp_err   = e;
                    pend = 1'b0;
                    if (drop_cnt > 0) drop_cnt--;
                    else exp_q.push_back('{pc: paddr, instr: mdata(paddr),
                                           ex: e ? `EX_FETCH_FAULT : `EX_NONE});
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: every consumed slot must match the head of the expected queue.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (reset && !flush && pipeline_out_valid && !stall) begin
                consumed++;
                last_pc = PC_out;
                last_ex = excep_out;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL deliver: got PC_out=%h instr=%h excep=%0d, required no delivery",
                             PC_out, instr_out, excep_out);
                end else begin
                    e = exp_q.pop_front();
                    if (PC_out !== e.pc || instr_out !== e.instr || excep_out !== e.ex) begin
                        n_fail++;
                        $display("FAIL deliver: got PC=%h instr=%h ex=%0d, required PC=%h instr=%h ex=%0d",
                                 PC_out, instr_out, excep_out, e.pc, e.instr, e.ex);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic wait_consumed(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(posedge clk); #2;
            if (consumed >= target) ok = 1'b1;
        end
    endtask

    task automatic wait_new_req(input int snap, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk); #1;
            if (req_count != snap) ok = 1'b1;
        end
    endtask

    task automatic wait_pend(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(posedge clk); #2;
            if (pend) ok = 1'b1;
        end
    endtask

    // One-cycle flush; the bench model discards queued work and expects the
    // response of any request still in flight to be swallowed.
    task automatic do_flush(input logic [31:0] target);
        flush       = 1'b1;
        redirect_pc = target;
        exp_q.delete();
        drop_cnt = pend ? 1 : 0;
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) drop_cnt++;
        @(posedge clk); #2;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (pipeline_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", pipeline_out_valid); end
        n_checks++; if (PC_out !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h required 0", PC_out); end
        n_checks++; if (instr_out !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h required 0", instr_out); end
        n_checks++; if (excep_out !== `EX_NONE) begin n_fail++; $display("FAIL rst_excep: got %0d required 0", excep_out); end
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b required 0", imem_req_valid); end
        @(posedge clk); #2;
        reset = 1'b1;
    endtask

    task automatic test_sequential();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk); #2;
            if (pipeline_out_valid && PC_out == 32'h8) begin
                ok    = 1'b1;
                stall = 1'b1;
            end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL seq_reach8: got timeout, required PC_out=8 valid"); end
        n_checks++; if (consumed !== 2) begin n_fail++; $display("FAIL seq_count: got %0d consumed, required 2", consumed); end
    endtask

    task automatic test_stall();
        bit ok;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (PC_out !== 32'h8 || instr_out !== mdata(32'h8) || excep_out !== `EX_NONE || pipeline_out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got PC=%h instr=%h ex=%0d v=%b, required PC=8 instr=%h ex=0 v=1",
                         i, PC_out, instr_out, excep_out, pipeline_out_valid, mdata(32'h8));
            end
            if (i >= 1) begin
                n_checks++;
                if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_noreq%0d: got %b required 0", i, imem_req_valid); end
            end
            @(posedge clk); #2;
        end
        stall   = 1'b0;
        mem_lat = 4;
        @(negedge clk);
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL skid_noreq: got %b required 0", imem_req_valid); end
        wait_consumed(4, ok);
        n_checks++; if (!ok || last_pc !== 32'hC) begin n_fail++; $display("FAIL stall_deliverC: got last PC %h (ok=%b), required 0000000c", last_pc, ok); end
    endtask

    task automatic test_flush();
        bit ok;
        int snap;
        int c0;
        wait_pend(ok);
        n_checks++; if (!ok || paddr !== 32'h10) begin n_fail++; $display("FAIL flush_wait10: got addr %h (ok=%b), required 00000010", paddr, ok); end
        snap = req_count;
        c0   = consumed;
        do_flush(32'h100);
        mem_lat = 1;
        @(negedge clk);
        n_checks++; if (pipeline_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b required 0", pipeline_out_valid); end
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_holdreq: got %b required 0", imem_req_valid); end
        wait_new_req(snap, ok);
        n_checks++; if (!ok || last_req_addr !== 32'h100) begin n_fail++; $display("FAIL flush_req: got %h (ok=%b), required 00000100", last_req_addr, ok); end
        n_checks++; if (drop_cnt !== 0) begin n_fail++; $display("FAIL flush_order: got stale response pending %0d, required 0", drop_cnt); end
        wait_consumed(c0 + 1, ok);
        n_checks++; if (!ok || last_pc !== 32'h100) begin n_fail++; $display("FAIL flush_deliver: got %h (ok=%b), required 00000100", last_pc, ok); end
    endtask

    task automatic test_misaligned();
        bit ok;
        int c0;
        int snap;
        c0 = consumed;
        do_flush(32'h102);
        exp_q.push_back('{pc: 32'h102, instr: 32'h0000_0013, ex: `EX_FETCH_MISALIGNED});
        wait_consumed(c0 + 1, ok);
        n_checks++; if (!ok || last_ex !== `EX_FETCH_MISALIGNED) begin n_fail++; $display("FAIL misal_ex: got %0d (ok=%b), required 2", last_ex, ok); end
        snap = req_count;
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++; if (req_count !== snap || pipeline_out_valid !== 1'b0) begin n_fail++; $display("FAIL misal_idle: got %0d reqs valid=%b, required 0 reqs valid=0", req_count - snap, pipeline_out_valid); end
        @(posedge clk); #2;
    endtask

    task automatic test_fault();
        bit ok;
        int c0;
        int snap;
        err_en   = 1'b1;
        err_addr = 32'h20;
        c0 = consumed;
        do_flush(32'h18);
        wait_consumed(c0 + 3, ok);
        n_checks++; if (!ok || last_pc !== 32'h20 || last_ex !== `EX_FETCH_FAULT) begin n_fail++; $display("FAIL fault: got PC %h ex %0d (ok=%b), required PC 00000020 ex 1", last_pc, last_ex, ok); end
        snap = req_count;
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++; if (req_count !== snap) begin n_fail++; $display("FAIL fault_idle: got %0d reqs, required 0", req_count - snap); end
        err_en = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        int snap;
        int c0;
        mem_lat = 4;
        do_flush(32'h200);
        wait_pend(ok);
        n_checks++; if (!ok || paddr !== 32'h200) begin n_fail++; $display("FAIL rw_req200: got %h (ok=%b), required 00000200", paddr, ok); end
        reset = 1'b0;
        flush = 1'b1;
        exp_q.delete();
        drop_cnt = pend ? 1 : 0;
        snap = req_count;
        @(posedge clk); #2;
        reset   = 1'b1;
        flush   = 1'b0;
        mem_lat = 1;
        @(negedge clk);
        n_checks++;
        if (pipeline_out_valid !== 1'b0 || PC_out !== 32'h0 || instr_out !== 32'h0 || excep_out !== `EX_NONE || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_outputs: got v=%b PC=%h instr=%h ex=%0d req=%b, required all zero",
                     pipeline_out_valid, PC_out, instr_out, excep_out, imem_req_valid);
        end
        c0 = consumed;
        wait_new_req(snap, ok);
        n_checks++; if (!ok || last_req_addr !== 32'h0) begin n_fail++; $display("FAIL rw_firstreq: got %h (ok=%b), required 00000000", last_req_addr, ok); end
        n_checks++; if (drop_cnt !== 0) begin n_fail++; $display("FAIL rw_stale: got stale response pending %0d, required 0", drop_cnt); end
        wait_consumed(c0 + 1, ok);
        n_checks++; if (!ok || last_pc !== 32'h0) begin n_fail++; $display("FAIL rw_deliver: got %h (ok=%b), required 00000000", last_pc, ok); end
    endtask

    initial begin
        reset          = 1'b0;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_misaligned();
        test_fault();
        test_reset_mid_wait();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
